// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud-period helper
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } uart_rx_state_e;

  // Clock cycles per bit on the line (integer division, truncating).
  function automatic int unsigned uart_pulse_width(input int unsigned clk_freq,
                                                   input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Resets to 1 so an idle line does not look like a start edge after reset.
module uart_sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  // Shift the raw input through two stages; second stage is the safe copy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ff_q <= '1;
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_WIDTH data bits LSB-first, optional even
// parity bit, one stop bit. Words are handed over on a valid/ready port.
// Optional feature: define UART_RX_PARITY_EN to expect an even parity bit
// after the data bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned CLK_FREQ   = 100_000_000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int unsigned PULSE_WIDTH      = uart_pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int unsigned CNT_W            = $clog2(PULSE_WIDTH) + 1;
  localparam int unsigned BIT_W            = ($clog2(DATA_WIDTH) > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

  logic                  rx_s;

  uart_rx_state_e        state_q, state_d;
  logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  frame_err_q, frame_err_d;
  logic                  deliver;
  logic                  cnt_zero;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  overrun_q, overrun_d;

`ifdef UART_RX_PARITY_EN
  logic                  parity_err_q, parity_err_d;
`endif

  uart_sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  assign cnt_zero = (clk_cnt_q == '0);

  // Frame state, bit timing counters and the data shift register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RX_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic: every bit is sampled when clk_cnt reaches zero, which
  // lands mid-bit because the start bit only waits half a bit period.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif

    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          clk_cnt_d = HALF_LOAD;
          state_d   = RX_START;
        end
      end

      RX_START: begin
        if (!cnt_zero) begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end else if (rx_s) begin
          state_d = RX_IDLE;
        end else begin
          clk_cnt_d = FULL_LOAD;
          bit_cnt_d = '0;
          state_d   = RX_DATA;
        end
      end

      RX_DATA: begin
        if (!cnt_zero) begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end else begin
          shift_d[bit_cnt_q] = rx_s;
          clk_cnt_d          = FULL_LOAD;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (!cnt_zero) begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end else begin
          parity_err_d = ^{shift_q, rx_s};
          clk_cnt_d    = FULL_LOAD;
          state_d      = RX_STOP;
        end
      end
`endif

      RX_STOP: begin
        if (!cnt_zero) begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end else if (rx_s) begin
          // A parity failure still consumes a good stop bit and returns to
          // IDLE; only a low stop bit needs the BREAK wait.
`ifdef UART_RX_PARITY_EN
          if (parity_err_q) begin
            frame_err_d = 1'b1;
          end else begin
            deliver = 1'b1;
          end
`else
          deliver = 1'b1;
`endif
          state_d = RX_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = RX_BREAK;
        end
      end

      RX_BREAK: begin
        if (rx_s) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Output holding register and the overrun pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  // A word arriving in the same cycle as a handshake replaces the consumed
  // one; otherwise a full holding register drops it and flags overrun.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = 1'b0;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    if (deliver) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at PULSE_WIDTH = 10 clocks per bit.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

  localparam int unsigned PW = 10;

  logic       clk_i;
  logic       rst_i;
  logic       rx_i;
  logic       valid_o;
  logic [7:0] data_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;

  int unsigned n_vec;
  int unsigned n_err;

  logic [7:0]  words[$];
  int unsigned fe_cnt;
  int unsigned ov_cnt;

  uart_rx #(
    .DATA_WIDTH (8),
    .BAUD_RATE  (100_000),
    .CLK_FREQ   (1_000_000)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Observe handshakes and pulses half a cycle away from the active edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (valid_o && ready_i) words.push_back(data_o);
      if (frame_err_o) fe_cnt++;
      if (overrun_o) ov_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    tick(PW);
  endtask

  // Leaves the line at the stop-bit level so a low stop can be extended.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_bit);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  // Bound on total run time; reports and aborts if anything stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned base;
    int unsigned fe0;
    int unsigned ov0;

    n_vec   = 0;
    n_err   = 0;
    fe_cnt  = 0;
    ov_cnt  = 0;
    rst_i   = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    tick(3);

    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", {24'd0, data_o}, 32'd0);
    check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    check("rst_ovr", {31'd0, overrun_o}, 32'd0);

    rst_i = 1'b0;
    tick(5);

    // Single frame
    base = words.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    tick(20);
    check("a5_count", words.size() - base, 32'd1);
    if (words.size() > base) check("a5_data", {24'd0, words[base]}, 32'hA5);
    check("a5_ferr", fe_cnt - fe0, 32'd0);
    check("a5_ovr", ov_cnt - ov0, 32'd0);
    check("a5_valid_clr", {31'd0, valid_o}, 32'd0);

    // Back-to-back frames with no idle between stop and start
    base = words.size(); fe0 = fe_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(20);
    check("b2b_count", words.size() - base, 32'd3);
    if (words.size() >= base + 3) begin
      check("b2b_w0", {24'd0, words[base]}, 32'h00);
      check("b2b_w1", {24'd0, words[base+1]}, 32'hFF);
      check("b2b_w2", {24'd0, words[base+2]}, 32'h3C);
    end
    check("b2b_ferr", fe_cnt - fe0, 32'd0);

    // Glitch rejection followed by a clean frame
    base = words.size(); fe0 = fe_cnt;
    rx_i = 1'b0;
    tick(3);
    rx_i = 1'b1;
    tick(20);
    check("glitch_count", words.size() - base, 32'd0);
    check("glitch_ferr", fe_cnt - fe0, 32'd0);
    send_frame(8'h55, 1'b1);
    tick(20);
    check("post_glitch_count", words.size() - base, 32'd1);
    if (words.size() > base) check("post_glitch_data", {24'd0, words[base]}, 32'h55);

    // Framing error with line held low afterwards
    base = words.size(); fe0 = fe_cnt;
    send_frame(8'h81, 1'b0);
    tick(30);
    check("ferr_pulse", fe_cnt - fe0, 32'd1);
    check("ferr_count", words.size() - base, 32'd0);
    rx_i = 1'b1;
    tick(30);
    check("break_count", words.size() - base, 32'd0);
    check("break_ferr", fe_cnt - fe0, 32'd1);

    // Overrun: holding register full, second word dropped
    base = words.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(20);
    check("ovr_valid", {31'd0, valid_o}, 32'd1);
    check("ovr_data", {24'd0, data_o}, 32'h11);
    check("ovr_pulse", ov_cnt - ov0, 32'd1);
    check("ovr_ferr", fe_cnt - fe0, 32'd0);
    ready_i = 1'b1;
    tick(3);
    check("ovr_drain_count", words.size() - base, 32'd1);
    if (words.size() > base) check("ovr_drain_data", {24'd0, words[base]}, 32'h11);
    check("ovr_drain_valid", {31'd0, valid_o}, 32'd0);

    // Reset mid-frame clears a held word and the partial frame
    base = words.size();
    ready_i = 1'b0;
    send_frame(8'h5A, 1'b1);
    tick(20);
    check("mid_hold_data", {24'd0, data_o}, 32'h5A);
    rx_i = 1'b0;
    tick(25);
    rst_i = 1'b1;
    rx_i  = 1'b1;
    tick(1);
    check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    check("mid_rst_data", {24'd0, data_o}, 32'd0);
    rst_i   = 1'b0;
    ready_i = 1'b1;
    tick(30);
    check("mid_rst_count", words.size() - base, 32'd0);
    check("mid_rst_valid2", {31'd0, valid_o}, 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so parity bit 1 is correct
    base = words.size(); fe0 = fe_cnt;
    send_frame_par(8'h07, 1'b1);
    tick(20);
    check("par_ok_count", words.size() - base, 32'd1);
    if (words.size() > base) check("par_ok_data", {24'd0, words[base]}, 32'h07);
    check("par_ok_ferr", fe_cnt - fe0, 32'd0);
    base = words.size(); fe0 = fe_cnt;
    send_frame_par(8'h07, 1'b0);
    tick(20);
    check("par_bad_count", words.size() - base, 32'd0);
    check("par_bad_ferr", fe_cnt - fe0, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
